// File: rtl/axis_eth_tx_min_pad.sv
// AXI-Stream Ethernet TX minimum-length padder: zero-pads short frames up to MIN_FRAME_LEN bytes.
// Optional truncation at MAX_FRAME_LEN is enabled by defining AXIS_ETH_TX_MIN_PAD_TRUNCATE_EN.
module axis_eth_tx_min_pad #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int MAX_FRAME_LEN = 1514,
  parameter int USER_WIDTH    = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_padded,
  output logic                  status_truncated
);

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
`ifdef AXIS_ETH_TX_MIN_PAD_TRUNCATE_EN
    ST_PAD  = 2'd1,
    ST_DROP = 2'd2
`else
    ST_PAD  = 2'd1
`endif
  } state_t;

  localparam logic [CNT_WIDTH:0]    MIN_LEN   = (CNT_WIDTH+1)'(MIN_FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [USER_WIDTH-1:0] USER_ZERO = {USER_WIDTH{1'b0}};
`ifdef AXIS_ETH_TX_MIN_PAD_TRUNCATE_EN
  localparam logic [CNT_WIDTH:0]    MAX_LEN   = (CNT_WIDTH+1)'(MAX_FRAME_LEN);
  localparam logic [USER_WIDTH-1:0] USER_BAD  = USER_WIDTH'(1);
`endif

  if (MIN_FRAME_LEN < 2 || MIN_FRAME_LEN > (2**CNT_WIDTH) - 1 || MAX_FRAME_LEN <= MIN_FRAME_LEN) begin : g_param_check
    $error("axis_eth_tx_min_pad: illegal MIN_FRAME_LEN/MAX_FRAME_LEN/CNT_WIDTH combination");
  end

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_WIDTH-1:0]    byte_cnt;
  logic [CNT_WIDTH-1:0]    cnt_nxt;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic [CNT_WIDTH:0]      cnt_p1;
  logic [USER_WIDTH-1:0]   pad_user;
  logic [USER_WIDTH-1:0]   pad_user_nxt;
  logic                    out_padded;
  logic                    padded_nxt;
  logic                    out_load;
  logic                    valid_nxt;
  logic [7:0]              data_nxt;
  logic                    last_nxt;
  logic [USER_WIDTH-1:0]   user_nxt;
`ifdef AXIS_ETH_TX_MIN_PAD_TRUNCATE_EN
  logic                    trunc_nxt;
`endif

  // cnt_p1 is one bit wider so the length compares never wrap; cnt_inc saturates.
  assign out_load = !m_axis_tvalid || m_axis_tready;
  assign cnt_p1   = {1'b0, byte_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign cnt_inc  = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + CNT_ONE;

`ifdef AXIS_ETH_TX_MIN_PAD_TRUNCATE_EN
  assign s_axis_tready = ((state == ST_PASS) && out_load) || (state == ST_DROP);
`else
  assign s_axis_tready = (state == ST_PASS) && out_load;
`endif

  // Padded-frame completion is flagged on the downstream handshake of its final beat.
  assign status_padded = m_axis_tvalid && m_axis_tready && m_axis_tlast && out_padded;

  // Next-state and output-register load decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = byte_cnt;
    pad_user_nxt = pad_user;
    data_nxt     = m_axis_tdata;
    last_nxt     = m_axis_tlast;
    user_nxt     = m_axis_tuser;
    padded_nxt   = out_padded;
`ifdef AXIS_ETH_TX_MIN_PAD_TRUNCATE_EN
    trunc_nxt    = 1'b0;
`endif
    if (out_load) begin
      valid_nxt = 1'b0;
    end else begin
      valid_nxt = m_axis_tvalid;
    end

    case (state)
      ST_PASS: begin
        if (s_axis_tvalid && out_load) begin
          valid_nxt  = 1'b1;
          data_nxt   = s_axis_tdata;
          padded_nxt = 1'b0;
          if (s_axis_tlast) begin
            if (cnt_p1 >= MIN_LEN) begin
              last_nxt = 1'b1;
              user_nxt = s_axis_tuser;
              cnt_nxt  = CNT_ZERO;
            end else begin
              // Short frame: hold back tlast/tuser until the last pad byte.
              last_nxt     = 1'b0;
              user_nxt     = USER_ZERO;
              pad_user_nxt = s_axis_tuser;
              cnt_nxt      = cnt_inc;
              state_nxt    = ST_PAD;
            end
          end else begin
`ifdef AXIS_ETH_TX_MIN_PAD_TRUNCATE_EN
            if (cnt_p1 == MAX_LEN) begin
              last_nxt  = 1'b1;
              user_nxt  = s_axis_tuser | USER_BAD;
              cnt_nxt   = CNT_ZERO;
              trunc_nxt = 1'b1;
              state_nxt = ST_DROP;
            end else begin
              last_nxt = 1'b0;
              user_nxt = USER_ZERO;
              cnt_nxt  = cnt_inc;
            end
`else
            last_nxt = 1'b0;
            user_nxt = USER_ZERO;
            cnt_nxt  = cnt_inc;
`endif
          end
        end else begin
          state_nxt = ST_PASS;
        end
      end

      ST_PAD: begin
        if (out_load) begin
          valid_nxt = 1'b1;
          data_nxt  = 8'h00;
          if (cnt_p1 >= MIN_LEN) begin
            last_nxt   = 1'b1;
            user_nxt   = pad_user;
            cnt_nxt    = CNT_ZERO;
            padded_nxt = 1'b1;
            state_nxt  = ST_PASS;
          end else begin
            last_nxt = 1'b0;
            user_nxt = USER_ZERO;
            cnt_nxt  = cnt_inc;
          end
        end else begin
          state_nxt = ST_PAD;
        end
      end

`ifdef AXIS_ETH_TX_MIN_PAD_TRUNCATE_EN
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt = ST_PASS;
        end else begin
          state_nxt = ST_DROP;
        end
      end
`endif

      default: begin
        state_nxt = ST_PASS;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_PASS;
      byte_cnt      <= CNT_ZERO;
      pad_user      <= USER_ZERO;
      out_padded    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= USER_ZERO;
    end else begin
      state         <= state_nxt;
      byte_cnt      <= cnt_nxt;
      pad_user      <= pad_user_nxt;
      out_padded    <= padded_nxt;
      m_axis_tvalid <= valid_nxt;
      m_axis_tdata  <= data_nxt;
      m_axis_tlast  <= last_nxt;
      m_axis_tuser  <= user_nxt;
    end
  end

`ifdef AXIS_ETH_TX_MIN_PAD_TRUNCATE_EN
  // Truncation pulse, high for the cycle after the cut beat is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_truncated <= 1'b0;
    end else begin
      status_truncated <= trunc_nxt;
    end
  end
`else
  assign status_truncated = 1'b0;
`endif

endmodule
